pwr_seq_ctrl: RTL and testbench
===============================

Name: pwr_seq_ctrl

Overview:
Sequenced power-domain enable controller for the test chip. It is the parametrised successor to the static 4-bit select decoder. It maps a select code to a one-hot block enable or an LDO+load enable pattern. It applies break-before-make sequencing between codes and an LDO settle interval before any LDO load is connected. It sits between the configuration/scan register and the analog enable pins.

Parameters:
N_BLK, 7, number of single-enable blocks (OTAs, comparators); codes 1..N_BLK
N_LOAD, 7, number of LDO load-current levels; codes N_BLK+2..N_BLK+1+N_LOAD
SEL_W, 4, select width; N_BLK+N_LOAD+1 must be ≤ 2^SEL_W-1 (elaboration error otherwise)
OFF_CYC, 4, break-before-make drain length in cycles (≥1)
SETTLE_CYC, 16, LDO settle length in cycles (≥1)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
req  in  1  single-cycle request strobe, samples sel
sel  in  SEL_W  requested code
out  out  N_BLK+N_LOAD+1  enable vector: [N_BLK-1:0] blocks, [N_BLK] LDO_en, [N_BLK+N_LOAD:N_BLK+1] loads
cur_sel  out  SEL_W  code currently applied
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when target pattern applied
err  out  1  one-cycle pulse on invalid code

Behaviour:
- Code map:
  - 0 = all off.
  - k in 1..N_BLK = out bit k-1 only.
  - N_BLK+1 = LDO_en only.
  - N_BLK+1+j (j in 1..N_LOAD) = LDO_en | load bit N_BLK+j.
  - Codes above N_BLK+N_LOAD+1 are invalid.
- Reset (async): out=0, cur_sel=0, busy=0, done=0, err=0, pending cleared, state STABLE. Reset mid-sequence drops every enable immediately.
- States: STABLE, DRAIN, LDO_SETTLE. Counter is sized to max(OFF_CYC,SETTLE_CYC).
- All outputs are registered. busy=1 exactly when state≠STABLE.
- Request in STABLE at cycle 0 with valid sel≠cur_sel:
  - If cur_sel=0 and target is a block or 0: at cycle 1, out=target, cur_sel=sel, done=1. State stays STABLE.
  - If cur_sel=0 and target is LDO family: at cycle 1, out=LDO_en only and state goes to LDO_SETTLE for SETTLE_CYC cycles. Target is applied on the cycle after the settle ends.
  - If cur_sel≠0, both codes are LDO family, and they differ: out=LDO_en only (load removed, LDO kept on) and state goes to DRAIN for OFF_CYC cycles. Then the target is applied with no settle.
  - Otherwise: out=0 and state goes to DRAIN for OFF_CYC cycles. Next:
    - target 0: out stays 0, cur_sel=0, done=1.
    - target block: target applied.
    - target LDO family: LDO_SETTLE, then target applied.
- Apply cycle: out=target pattern, cur_sel=sel, done=1, state STABLE. No cycle ever has two block bits set, or a load bit set without LDO_en.
- Request with sel==cur_sel in STABLE: ignored, done=0, no output change.
- Invalid code (any state): err=1 next cycle. The request is dropped and pending is unchanged.
- Request while busy:
  - The code is stored in a single pending slot; last request wins.
  - On the apply cycle, if pending is set, the pending code is processed on the following cycle as a fresh STABLE request, and pending is cleared.
  - A pending code equal to the new cur_sel is discarded silently.
- Simultaneous req and apply cycle: the incoming req overwrites pending.

Test Plan:
- Defaults, from reset, req sel=3 → cycle 1: out=0x0004, cur_sel=3, done=1, busy never high.
- Defaults, cur_sel=3, req sel=10 → cycles 1-4 out=0x0000; cycles 5-20 out=0x0080; cycle 21 out=0x0280, done=1, cur_sel=10; busy=1 for cycles 1-20.
- Defaults, cur_sel=10, req sel=15 → cycles 1-4 out=0x0080 (LDO held); cycle 5 out=0x4080, done=1; no settle phase.
- Defaults, cur_sel=2, req sel=5, then req sel=0 at cycle 2 and req sel=6 at cycle 3 → 5 applied at cycle 5; then pending 6 sequence: out=0 for 4 cycles, then out=0x0020 with done=1 (request 0 overwritten).
- N_BLK=3, N_LOAD=2, req sel=9 → err=1 for one cycle, out and cur_sel unchanged; req sel=6 from off → out=LDO|load2 = 0x28 after SETTLE_CYC.
- Assert rst during LDO_SETTLE → out=0, busy=0, cur_sel=0 asynchronously; first post-reset req behaves as from reset.

Source files
------------

// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl
// Sequenced power-domain enable controller. It maps a select code to either a
// one-hot block enable or an LDO enable plus one load enable. It inserts a
// break-before-make drain between codes and an LDO settle interval before
// any LDO load is connected.
//
// Code map:
//   0                          all off
//   1..N_BLK                   block enable bit code-1
//   N_BLK+1                    LDO_en (bit N_BLK) only
//   N_BLK+1+j (j=1..N_LOAD)    LDO_en | load bit N_BLK+j
//   anything larger            invalid; pulses err
//
// Ports:
//   clk      system clock
//   rst      asynchronous active-high reset; drops every enable at once
//   req      single-cycle request strobe, samples sel
//   sel      requested code
//   out      enable vector: [N_BLK-1:0] blocks, [N_BLK] LDO_en, [N_BLK+N_LOAD:N_BLK+1] loads
//   cur_sel  code currently applied
//   busy     high while a drain or settle sequence is running
//   done     one-cycle pulse when the target pattern is applied
//   err      one-cycle pulse when an invalid code is requested
module pwr_seq_ctrl #(
    parameter int N_BLK      = 7,
    parameter int N_LOAD     = 7,
    parameter int SEL_W      = 4,
    parameter int OFF_CYC    = 4,
    parameter int SETTLE_CYC = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    input  logic [SEL_W-1:0]         sel,
    output logic [N_BLK+N_LOAD:0]    out,
    output logic [SEL_W-1:0]         cur_sel,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int OUT_W   = N_BLK + N_LOAD + 1;
    localparam int MAX_CYC = (OFF_CYC > SETTLE_CYC) ? OFF_CYC : SETTLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [SEL_W:0]     MAX_CODE    = (SEL_W+1)'(N_BLK + N_LOAD + 1);
    localparam logic [SEL_W-1:0]   LDO_CODE    = SEL_W'(N_BLK + 1);
    localparam logic [OUT_W-1:0]   LDO_ONLY    = OUT_W'(1) << N_BLK;
    localparam logic [CNT_W-1:0]   OFF_LOAD    = CNT_W'(OFF_CYC - 1);
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

    if (N_BLK + N_LOAD + 1 > (1 << SEL_W) - 1) begin : g_bad_sel_w
        $error("pwr_seq_ctrl: SEL_W too narrow for N_BLK+N_LOAD+1 codes");
    end
    if (OFF_CYC < 1 || SETTLE_CYC < 1) begin : g_bad_cyc
        $error("pwr_seq_ctrl: OFF_CYC and SETTLE_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_STABLE,
        ST_DRAIN,
        ST_SETTLE
    } state_t;

    // Every valid code lights bit code-1; load codes additionally keep LDO_en.
    function automatic logic [OUT_W-1:0] pattern(input logic [SEL_W-1:0] code);
        logic [OUT_W-1:0] p;
        p = '0;
        if (code != '0) begin
            p = OUT_W'(1) << (code - 1'b1);
            if (code > LDO_CODE) p = p | LDO_ONLY;
        end
        return p;
    endfunction

    function automatic logic is_ldo(input logic [SEL_W-1:0] code);
        return code >= LDO_CODE;
    endfunction

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [SEL_W-1:0] tgt, tgt_next;
    logic [SEL_W-1:0] pend, pend_next;
    logic             pend_vld, pend_vld_next;
    logic [OUT_W-1:0] out_next;
    logic [SEL_W-1:0] cur_next;
    logic             done_next, err_next;
    logic             sel_ok, req_ok;
    logic             start;
    logic [SEL_W-1:0] start_code;

    // One spare bit so the range check stays meaningful when every code is valid.
    assign sel_ok = {1'b0, sel} <= MAX_CODE;
    assign req_ok = req && sel_ok;
    assign busy   = (state != ST_STABLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_STABLE;
            cnt      <= '0;
            tgt      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            out      <= '0;
            cur_sel  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            tgt      <= tgt_next;
            pend     <= pend_next;
            pend_vld <= pend_vld_next;
            out      <= out_next;
            cur_sel  <= cur_next;
            done     <= done_next;
            err      <= err_next;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_next    = state;
        cnt_next      = cnt;
        tgt_next      = tgt;
        pend_next     = pend;
        pend_vld_next = pend_vld;
        out_next      = out;
        cur_next      = cur_sel;
        done_next     = 1'b0;
        err_next      = req && !sel_ok;
        start         = 1'b0;
        start_code    = '0;

        case (state)
            ST_STABLE: begin
                // A live request beats a queued one; either way the slot empties.
                if (req_ok) begin
                    start         = 1'b1;
                    start_code    = sel;
                    pend_vld_next = 1'b0;
                end else if (pend_vld) begin
                    start         = 1'b1;
                    start_code    = pend;
                    pend_vld_next = 1'b0;
                end

                if (start && start_code != cur_sel) begin
                    tgt_next = start_code;
                    if (cur_sel == '0) begin
                        if (is_ldo(start_code)) begin
                            out_next   = LDO_ONLY;
                            state_next = ST_SETTLE;
                            cnt_next   = SETTLE_LOAD;
                        end else begin
                            out_next  = pattern(start_code);
                            cur_next  = start_code;
                            done_next = 1'b1;
                        end
                    end else if (is_ldo(cur_sel) && is_ldo(start_code)) begin
                        // Swap loads without dropping the regulator.
                        out_next   = LDO_ONLY;
                        state_next = ST_DRAIN;
                        cnt_next   = OFF_LOAD;
                    end else begin
                        out_next   = '0;
                        state_next = ST_DRAIN;
                        cnt_next   = OFF_LOAD;
                    end
                end
            end

            ST_DRAIN, ST_SETTLE: begin
                if (req_ok) begin
                    pend_next     = sel;
                    pend_vld_next = 1'b1;
                end

                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (state == ST_DRAIN && is_ldo(tgt) && !out[N_BLK]) begin
                    // LDO was off during the drain, so it must settle first.
                    out_next   = LDO_ONLY;
                    state_next = ST_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    out_next   = pattern(tgt);
                    cur_next   = tgt;
                    done_next  = 1'b1;
                    state_next = ST_STABLE;
                end
            end

            default: state_next = ST_STABLE;
        endcase
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Testbench for pwr_seq_ctrl: directed test-plan steps followed by random
// requests, all compared against a transaction-level reference model that
// expands each code change into its expected per-cycle output sequence.
module tb_pwr_seq_ctrl;

    localparam int N_BLK      = 7;
    localparam int N_LOAD     = 7;
    localparam int SEL_W      = 4;
    localparam int OFF_CYC    = 4;
    localparam int SETTLE_CYC = 16;
    localparam int OUT_W      = N_BLK + N_LOAD + 1;
    localparam int MAX_CODE   = N_BLK + N_LOAD + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic [OUT_W-1:0] out;
    logic [SEL_W-1:0] cur_sel;
    logic             busy, done, err;

    // Second instance with a reduced code space (3 blocks, 2 loads).
    logic             s_req = 1'b0;
    logic [3:0]       s_sel = '0;
    logic [5:0]       s_out;
    logic [3:0]       s_cur;
    logic             s_busy, s_done, s_err;

    always #5 clk = ~clk;

    pwr_seq_ctrl #(
        .N_BLK(N_BLK), .N_LOAD(N_LOAD), .SEL_W(SEL_W),
        .OFF_CYC(OFF_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel),
        .out(out), .cur_sel(cur_sel), .busy(busy), .done(done), .err(err)
    );

    pwr_seq_ctrl #(
        .N_BLK(3), .N_LOAD(2), .SEL_W(4),
        .OFF_CYC(OFF_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut_small (
        .clk(clk), .rst(rst), .req(s_req), .sel(s_sel),
        .out(s_out), .cur_sel(s_cur), .busy(s_busy), .done(s_done), .err(s_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [OUT_W-1:0] out;
        int               cur;
        bit               busy;
        bit               done;
    } rec_t;

    rec_t m_now;
    rec_t m_seq[$];
    bit   m_pend_vld;
    int   m_pend;
    bit   m_err;

    function automatic logic [OUT_W-1:0] pat(input int c);
        logic [OUT_W-1:0] p;
        p = '0;
        if (c >= 1 && c <= N_BLK) p[c-1] = 1'b1;
        else if (c == N_BLK + 1) p[N_BLK] = 1'b1;
        else if (c > N_BLK + 1) begin
            p[N_BLK] = 1'b1;
            p[N_BLK + (c - N_BLK - 1)] = 1'b1;
        end
        return p;
    endfunction

    function automatic bit is_ldo(input int c);
        return c > N_BLK;
    endfunction

    task automatic m_reset();
        m_now.out  = '0;
        m_now.cur  = 0;
        m_now.busy = 1'b0;
        m_now.done = 1'b0;
        m_seq.delete();
        m_pend_vld = 1'b0;
        m_pend     = 0;
        m_err      = 1'b0;
    endtask

    // Expand a code change into the cycles the outputs must show.
    task automatic m_plan(input int from, input int to);
        rec_t r;
        r.cur  = from;
        r.busy = 1'b1;
        r.done = 1'b0;
        if (from == 0) begin
            r.out = pat(N_BLK + 1);
            if (is_ldo(to)) repeat (SETTLE_CYC) m_seq.push_back(r);
        end else if (is_ldo(from) && is_ldo(to)) begin
            r.out = pat(N_BLK + 1);
            repeat (OFF_CYC) m_seq.push_back(r);
        end else begin
            r.out = '0;
            repeat (OFF_CYC) m_seq.push_back(r);
            if (is_ldo(to)) begin
                r.out = pat(N_BLK + 1);
                repeat (SETTLE_CYC) m_seq.push_back(r);
            end
        end
        r.out  = pat(to);
        r.cur  = to;
        r.busy = 1'b0;
        r.done = 1'b1;
        m_seq.push_back(r);
    endtask

    task automatic m_step(input bit rq, input int s);
        bit ok;
        bit start;
        int code;
        ok    = rq && (s <= MAX_CODE);
        start = 1'b0;
        code  = 0;
        m_err = rq && !ok;
        if (m_now.busy) begin
            if (ok) begin
                m_pend_vld = 1'b1;
                m_pend     = s;
            end
            if (m_seq.size() == 0) begin
                check("model_underflow", 32'd1, 32'd0);
                m_now.busy = 1'b0;
            end else begin
                m_now = m_seq.pop_front();
            end
        end else begin
            if (ok) begin
                start = 1'b1; code = s; m_pend_vld = 1'b0;
            end else if (m_pend_vld) begin
                start = 1'b1; code = m_pend; m_pend_vld = 1'b0;
            end
            if (start && code != m_now.cur) begin
                m_plan(m_now.cur, code);
                m_now = m_seq.pop_front();
            end else begin
                m_now.done = 1'b0;
            end
        end
    endtask

    // One clock: drive inputs, advance model, compare all outputs after the edge.
    task automatic step(input bit rq, input int s, input string tag);
        req = rq;
        sel = SEL_W'(s);
        @(posedge clk);
        m_step(rq, s);
        #1;
        req = 1'b0;
        check({tag, ".out"},     32'(out),     32'(m_now.out));
        check({tag, ".cur_sel"}, 32'(cur_sel), 32'(m_now.cur));
        check({tag, ".busy"},    32'(busy),    32'(m_now.busy));
        check({tag, ".done"},    32'(done),    32'(m_now.done));
        check({tag, ".err"},     32'(err),     32'(m_err));
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) step(1'b0, 0, tag);
    endtask

    initial begin
        m_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out",     32'(out),     32'h0);
        check("reset.cur_sel", 32'(cur_sel), 32'h0);
        check("reset.busy",    32'(busy),    32'h0);
        check("reset.done",    32'(done),    32'h0);
        check("reset.err",     32'(err),     32'h0);
        rst = 1'b0;

        // Block from off: applied in one cycle, never busy.
        step(1'b1, 3, "blk3");
        check("blk3.const_out", 32'(out), 32'h0004);
        check("blk3.const_done", 32'(done), 32'h1);
        check("blk3.const_busy", 32'(busy), 32'h0);

        // Block to LDO load: drain, settle, apply.
        step(1'b1, 10, "to10_c1");
        check("to10.c1_out", 32'(out), 32'h0000);
        check("to10.c1_busy", 32'(busy), 32'h1);
        idle(3, "to10_drain");
        step(1'b0, 0, "to10_c5");
        check("to10.c5_out", 32'(out), 32'h0080);
        idle(15, "to10_settle");
        check("to10.c20_busy", 32'(busy), 32'h1);
        step(1'b0, 0, "to10_c21");
        check("to10.c21_out", 32'(out), 32'h0280);
        check("to10.c21_cur", 32'(cur_sel), 32'd10);
        check("to10.c21_done", 32'(done), 32'h1);

        // Load to load: LDO held, no settle phase.
        step(1'b1, 15, "to15_c1");
        check("to15.c1_out", 32'(out), 32'h0080);
        idle(3, "to15_drain");
        step(1'b0, 0, "to15_c5");
        check("to15.c5_out", 32'(out), 32'h4080);
        check("to15.c5_done", 32'(done), 32'h1);

        // Get to block 2, then exercise the pending slot (last request wins).
        step(1'b1, 2, "to2");
        idle(4, "to2_wait");
        check("to2.cur", 32'(cur_sel), 32'd2);
        step(1'b1, 5, "pend_c1");
        step(1'b0, 0, "pend_c2");
        step(1'b1, 0, "pend_c3");
        step(1'b1, 6, "pend_c4");
        step(1'b0, 0, "pend_c5");
        check("pend.c5_cur", 32'(cur_sel), 32'd5);
        check("pend.c5_out", 32'(out), 32'h0010);
        idle(4, "pend_drain");
        check("pend.c9_out", 32'(out), 32'h0000);
        step(1'b0, 0, "pend_c10");
        check("pend.c10_out", 32'(out), 32'h0020);
        check("pend.c10_done", 32'(done), 32'h1);

        // Reduced instance: invalid code, then LDO load from off.
        s_req = 1'b1; s_sel = 4'd9;
        step(1'b0, 0, "small_inv");
        s_req = 1'b0;
        check("small.err", 32'(s_err), 32'h1);
        check("small.inv_out", 32'(s_out), 32'h00);
        check("small.inv_cur", 32'(s_cur), 32'h0);
        s_req = 1'b1; s_sel = 4'd6;
        step(1'b0, 0, "small_c1");
        s_req = 1'b0;
        check("small.err_cleared", 32'(s_err), 32'h0);
        check("small.c1_out", 32'(s_out), 32'h08);
        check("small.c1_busy", 32'(s_busy), 32'h1);
        idle(SETTLE_CYC - 1, "small_settle");
        check("small.c16_out", 32'(s_out), 32'h08);
        step(1'b0, 0, "small_c17");
        check("small.c17_out", 32'(s_out), 32'h28);
        check("small.c17_cur", 32'(s_cur), 32'd6);
        check("small.c17_done", 32'(s_done), 32'h1);

        // Reset during LDO settle drops everything asynchronously.
        step(1'b1, 9, "rst_seq");
        idle(6, "rst_seq_wait");
        check("rst.pre_out", 32'(out), 32'h0080);
        #2;
        rst = 1'b1;
        #1;
        check("rst.async_out",  32'(out),     32'h0);
        check("rst.async_busy", 32'(busy),    32'h0);
        check("rst.async_cur",  32'(cur_sel), 32'h0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b1, 3, "post_rst");
        check("post_rst.out", 32'(out), 32'h0004);
        check("post_rst.done", 32'(done), 32'h1);

        // Random requests, including bursts while busy.
        for (int i = 0; i < 600; i++) begin
            bit rq;
            int s;
            rq = ($urandom_range(0, 3) == 0);
            s  = $urandom_range(0, 15);
            step(rq, s, "rnd");
        end
        idle(40, "drain_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
